mp_csa_resolver: RTL and testbench

Parametrised carry-save accumulator with chunked carry resolution and optional conditional final subtraction, for the Montgomery multiplier datapath. It holds a redundant (sum, carry) value and accepts one add or add-and-halve per cycle. On request it ripple-resolves the value into binary CHUNK bits per cycle, then optionally subtracts the modulus when the result is not below it. It is the generalised successor of the fixed 514-bit adder and sits between the multiplier controller and the result register file.

---
 rtl/mp_pkg.sv | 31 +++
 rtl/mp_csa_row.sv | 33 +++
 rtl/mp_csa_resolver.sv | 254 +++++++++++++++++++++++++
 tb/tb_mp_csa_resolver.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared types and helpers for the carry-save accumulator / resolver datapath.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mp_pkg;

    // Command encoding on cmd_op
    typedef enum logic [1:0] {
        CMD_CLEAR     = 2'b00,
        CMD_ACC       = 2'b01,
        CMD_ACC_SHIFT = 2'b10,
        CMD_RESOLVE   = 2'b11
    } cmd_op_t;

    // Resolver sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RES  = 2'b01,
        ST_SUB  = 2'b10
    } state_t;

    // Number of CHUNK-wide slices needed to cover WIDTH bits
    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Counter width able to index n slices (at least one bit)
    function automatic int cntw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp_csa_row.sv
// 3:2 compressor row: folds addend a into the redundant pair (s, c), optional >>1.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the outputs.
//
// Ports: s, c (current redundant value), a (addend), shift (halve after add),
//        s_nxt, c_nxt (new redundant value). Carry out of the MSB is dropped.
module mp_csa_row #(
    parameter int WIDTH = 514
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] a,
    input  logic             shift,
    output logic [WIDTH-1:0] s_nxt,
    output logic [WIDTH-1:0] c_nxt
);

    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH-1:0] maj_bits;
    logic             unused_maj_msb;

    assign sum_bits = s ^ c ^ a;
    assign maj_bits = (s & c) | (s & a) | (c & a);

    // The majority MSB would carry past the datapath width and is discarded.
    assign unused_maj_msb = maj_bits[WIDTH-1];

    // Unshifted carry vector is maj << 1; shifting it right again is just maj
    // with a zero MSB. Sum bit 0 is even by caller contract when halving.
    assign s_nxt = shift ? {1'b0, sum_bits[WIDTH-1:1]} : sum_bits;
    assign c_nxt = shift ? {1'b0, maj_bits[WIDTH-2:0]} : {maj_bits[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/mp_csa_resolver.sv
// Carry-save accumulator with chunked carry resolution and optional conditional subtract.
// Latency: ACC/ACC_SHIFT/CLEAR 1 cycle; RESOLVE NCHUNK cycles, 2*NCHUNK with subtract.
// Backpressure: cmd_ready low while resolving; commands are not queued.
//
// Ports: clk/resetn (async active-low); cmd_valid/cmd_ready/cmd_op command handshake;
//        cond_sub + in_a (addend, or modulus on RESOLVE); lsb0/lsb1 low bits of S+C;
//        result/borrow held resolved value and subtract flag; done one-cycle pulse.
// Build option: define MP_RESOLVER_COND_SUB_EN to include the conditional subtract
//        (SUB state, modulus and difference registers, borrow). Without it cond_sub is
//        ignored and borrow reads 0.
module mp_csa_resolver
    import mp_pkg::*;
#(
    parameter int WIDTH = 514,
    parameter int CHUNK = 103
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cond_sub,
    input  logic [WIDTH-1:0] in_a,
    output logic             lsb0,
    output logic             lsb1,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             borrow
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int KW     = cntw(NCHUNK);
    localparam int TOPLO  = (NCHUNK - 1) * CHUNK;
    localparam int TOPW   = WIDTH - TOPLO;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic             cin_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic             done_q;

    cmd_op_t          op;
    logic [WIDTH-1:0] row_s;
    logic [WIDTH-1:0] row_c;

    logic             k_last;
    logic [TOPW-1:0]  s_top;
    logic [TOPW-1:0]  c_top;
    logic [CHUNK-1:0] s_k;
    logic [CHUNK-1:0] c_k;
    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic [CHUNK:0]   ch_sum;
    logic             ch_cout;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] fin_val;
    logic             fin_borrow;
    logic             fin_go;

`ifdef MP_RESOLVER_COND_SUB_EN
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] d_q;
    logic             sub_q;
    logic [TOPW-1:0]  r_top;
    logic [TOPW-1:0]  nm_top;
    logic [CHUNK-1:0] r_k;
    logic [CHUNK-1:0] nm_k;
`else
    logic             unused_cond_sub;
    assign unused_cond_sub = cond_sub;
`endif

    assign op = cmd_op_t'(cmd_op);

    mp_csa_row #(
        .WIDTH (WIDTH)
    ) u_row (
        .s     (s_q),
        .c     (c_q),
        .a     (in_a),
        .shift (op == CMD_ACC_SHIFT),
        .s_nxt (row_s),
        .c_nxt (row_c)
    );

    assign k_last = (k_q == KLAST);

    // Top slice may be narrower than CHUNK; extract it separately and zero-extend.
    assign s_top = s_q[TOPLO +: TOPW];
    assign c_top = c_q[TOPLO +: TOPW];

    always_comb begin
        s_k = '0;
        c_k = '0;
        for (int j = 0; j < NCHUNK - 1; j++) begin
            if (int'(k_q) == j) begin
                s_k = s_q[j*CHUNK +: CHUNK];
                c_k = c_q[j*CHUNK +: CHUNK];
            end
        end
        if (k_last) begin
            s_k = CHUNK'(s_top);
            c_k = CHUNK'(c_top);
        end
    end

`ifdef MP_RESOLVER_COND_SUB_EN
    // Invert before widening so the padding above the top slice stays zero and
    // the carry out lands exactly at bit TOPW.
    assign r_top  = r_q[TOPLO +: TOPW];
    assign nm_top = ~m_q[TOPLO +: TOPW];

    always_comb begin
        r_k  = '0;
        nm_k = '0;
        for (int j = 0; j < NCHUNK - 1; j++) begin
            if (int'(k_q) == j) begin
                r_k  = r_q[j*CHUNK +: CHUNK];
                nm_k = ~m_q[j*CHUNK +: CHUNK];
            end
        end
        if (k_last) begin
            r_k  = CHUNK'(r_top);
            nm_k = CHUNK'(nm_top);
        end
    end

    // One chunk adder shared by the resolve pass and the subtract pass.
    assign op_a = (state_q == ST_SUB) ? r_k  : s_k;
    assign op_b = (state_q == ST_SUB) ? nm_k : c_k;
    assign base = (state_q == ST_SUB) ? d_q  : r_q;
`else
    assign op_a = s_k;
    assign op_b = c_k;
    assign base = r_q;
`endif

    assign ch_sum  = {1'b0, op_a} + {1'b0, op_b} + {{CHUNK{1'b0}}, cin_q};
    assign ch_cout = k_last ? ch_sum[TOPW] : ch_sum[CHUNK];

    // Destination register with slice k replaced by the fresh chunk sum.
    always_comb begin
        merged = base;
        for (int j = 0; j < NCHUNK - 1; j++) begin
            if (int'(k_q) == j) begin
                merged[j*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
            end
        end
        if (k_last) begin
            merged[TOPLO +: TOPW] = ch_sum[TOPW-1:0];
        end
    end

`ifdef MP_RESOLVER_COND_SUB_EN
    // No carry out of R + ~M + 1 means R < M: keep R and flag the borrow.
    assign fin_borrow = (state_q == ST_SUB) && !ch_cout;
    assign fin_val    = fin_borrow ? r_q : merged;
    assign fin_go     = k_last && ((state_q == ST_SUB) || ((state_q == ST_RES) && !sub_q));
`else
    assign fin_borrow = 1'b0;
    assign fin_val    = merged;
    assign fin_go     = k_last;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            cin_q    <= 1'b0;
            s_q      <= '0;
            c_q      <= '0;
            r_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef MP_RESOLVER_COND_SUB_EN
            m_q      <= '0;
            d_q      <= '0;
            sub_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (cmd_valid) begin
                    case (op)
                        CMD_CLEAR: begin
                            s_q <= '0;
                            c_q <= '0;
                        end
                        CMD_ACC, CMD_ACC_SHIFT: begin
                            s_q <= row_s;
                            c_q <= row_c;
                        end
                        CMD_RESOLVE: begin
                            state_q <= ST_RES;
                            k_q     <= '0;
                            cin_q   <= 1'b0;
`ifdef MP_RESOLVER_COND_SUB_EN
                            m_q     <= in_a;
                            sub_q   <= cond_sub;
`endif
                        end
                        default: ;
                    endcase
                end
            end else begin
                cin_q <= ch_cout;
`ifdef MP_RESOLVER_COND_SUB_EN
                if (state_q == ST_SUB) begin
                    d_q <= merged;
                end else begin
                    r_q <= merged;
                end
`else
                r_q <= merged;
`endif
                if (fin_go) begin
                    // Resolved value becomes the new accumulator seed.
                    res_q    <= fin_val;
                    borrow_q <= fin_borrow;
                    done_q   <= 1'b1;
                    s_q      <= fin_val;
                    c_q      <= '0;
                    state_q  <= ST_IDLE;
                    k_q      <= '0;
                end
`ifdef MP_RESOLVER_COND_SUB_EN
                else if (k_last) begin
                    state_q <= ST_SUB;
                    k_q     <= '0;
                    cin_q   <= 1'b1;
                end
`endif
                else begin
                    k_q <= k_q + KW'(1);
                end
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign lsb0      = s_q[0] ^ c_q[0];
    assign lsb1      = s_q[1] ^ c_q[1] ^ (s_q[0] & c_q[0]);
    assign result    = res_q;
    assign done      = done_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_mp_csa_resolver.sv
// Self-checking bench for mp_csa_resolver at WIDTH=16, CHUNK=6 (three chunks).
// Latency: n/a.
// Backpressure: n/a.
module tb_mp_csa_resolver;

    localparam int W   = 16;
    localparam int CH  = 6;
    localparam int NCH = 3;
    localparam int LIM = 1 << 14;
`ifdef MP_RESOLVER_COND_SUB_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_ACC = 2'b01;
    localparam logic [1:0] OP_SHF = 2'b10;
    localparam logic [1:0] OP_RES = 2'b11;

    logic         clk;
    logic         resetn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic         cond_sub;
    logic [W-1:0] in_a;
    logic         lsb0;
    logic         lsb1;
    logic [W-1:0] result;
    logic         done;
    logic         borrow;

    int n_checks = 0;
    int n_err    = 0;
    int model_v  = 0;

    mp_csa_resolver #(
        .WIDTH (W),
        .CHUNK (CH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cond_sub  (cond_sub),
        .in_a      (in_a),
        .lsb0      (lsb0),
        .lsb1      (lsb1),
        .result    (result),
        .done      (done),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a1;
        logic [W-1:0] a2;
        logic         cs;
        logic [W-1:0] m;
        logic [W-1:0] exp_r;
        logic         exp_b;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: resolve returns V, or V-M when subtraction enabled and V >= M.
    function automatic void ref_resolve(input int v, input bit cs, input int m,
                                        output int r, output bit b, output int lat);
        if (EN && cs) begin
            lat = 2 * NCH;
            if (v >= m) begin
                r = v - m;
                b = 1'b0;
            end else begin
                r = v;
                b = 1'b1;
            end
        end else begin
            lat = NCH;
            r   = v;
            b   = 1'b0;
        end
    endfunction

    task automatic send(input logic [1:0] op, input logic [W-1:0] a);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        in_a      = a;
        cond_sub  = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic do_resolve(input logic cs, input logic [W-1:0] m, input logic [W-1:0] exp_r,
                              input logic exp_b, input int exp_lat, input string tag);
        int cyc;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_RES;
        cond_sub  = cs;
        in_a      = m;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        in_a      = W'($urandom);
        cond_sub  = ~cs;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_result"}, 32'(result), 32'(exp_r));
        chk({tag, "_borrow"}, 32'(borrow), 32'(exp_b));
        chk({tag, "_lsbs"}, {30'd0, lsb1, lsb0}, {30'd0, exp_r[1:0]});
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        model_v = int'(exp_r);
    endtask

    initial begin
        int r, lat, a, cyc, npulse;
        bit b;
        logic [W-1:0] er;
        logic         eb;

        vt[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h0000, 16'h2233, 1'b0};
        vt[1] = '{16'h1234, 16'h0FFF, 1'b1, 16'h2000, 16'h0233, 1'b0};
        vt[2] = '{16'h1234, 16'h0FFF, 1'b1, 16'h3000, 16'h2233, 1'b1};
        vt[3] = '{16'hFFFF, 16'h0002, 1'b0, 16'h0000, 16'h0001, 1'b0};
        vt[4] = '{16'h8000, 16'h7FFF, 1'b1, 16'hFFFF, 16'h0000, 1'b0};
        vt[5] = '{16'h0001, 16'h0000, 1'b1, 16'h0002, 16'h0001, 1'b1};
        vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'hFFFD, 1'b0};
        vt[7] = '{16'h0FC0, 16'h0041, 1'b0, 16'h0000, 16'h1001, 1'b0};

        cmd_valid = 1'b0;
        cmd_op    = OP_CLR;
        cond_sub  = 1'b0;
        in_a      = '0;
        resetn    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_lsbs", {30'd0, lsb1, lsb0}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Table-driven: CLEAR, two ACCs, RESOLVE.
        for (int i = 0; i < 8; i++) begin
            send(OP_CLR, '0);
            send(OP_ACC, vt[i].a1);
            send(OP_ACC, vt[i].a2);
            if (EN) begin
                er = vt[i].exp_r;
                eb = vt[i].exp_b;
            end else begin
                er = W'(vt[i].a1 + vt[i].a2);
                eb = 1'b0;
            end
            do_resolve(vt[i].cs, vt[i].m, er, eb, (EN && vt[i].cs) ? 2*NCH : NCH,
                       $sformatf("vec%0d", i));
        end

        // ACC_SHIFT halves the sum.
        send(OP_CLR, '0);
        send(OP_SHF, 16'h0006);
        chk("shift_lsbs", {30'd0, lsb1, lsb0}, 32'd3);
        do_resolve(1'b0, '0, 16'h0003, 1'b0, NCH, "shift");

        // Command held during RES: refused until done, accepted the cycle after.
        send(OP_CLR, '0);
        send(OP_ACC, 16'h0100);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_RES;
        cond_sub  = 1'b0;
        in_a      = '0;
        @(posedge clk);
        #1;
        cmd_op = OP_ACC;
        in_a   = 16'h0001;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!done) begin
                chk("busy_ready", 32'(cmd_ready), 32'd0);
                chk("busy_hold", 32'(lsb0), 32'd0);
            end
        end
        chk("busy_latency", 32'(cyc), 32'(NCH));
        chk("busy_result", 32'(result), 32'h0100);
        chk("busy_ready_done", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("acc_after_done", 32'(lsb0), 32'd1);
        do_resolve(1'b0, '0, 16'h0101, 1'b0, NCH, "busy_tail");

        // Reset during the second chunk aborts without a done pulse.
        send(OP_CLR, '0);
        send(OP_ACC, 16'h1237);
        chk("pre_rst_lsbs", {30'd0, lsb1, lsb0}, 32'd3);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_RES;
        cond_sub  = 1'b1;
        in_a      = 16'h0001;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_lsbs", {30'd0, lsb1, lsb0}, 32'd0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) npulse++;
        end
        chk("abort_no_pulse", 32'(npulse), 32'd0);
        model_v = 0;

        // Randomized back-to-back accumulation against an integer value model.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                a = $urandom_range(0, 2 * model_v + 1);
                b = 1'($urandom_range(0, 1));
                ref_resolve(model_v, b, a, r, eb, lat);
                do_resolve(b, W'(a), W'(r), eb, lat, "rnd_res");
            end else begin
                @(negedge clk);
                cmd_valid = 1'b1;
                cond_sub  = 1'($urandom_range(0, 1));
                if (model_v >= LIM - 2) begin
                    cmd_op  = OP_CLR;
                    in_a    = W'($urandom);
                    model_v = 0;
                end else if (r < 7) begin
                    a = $urandom_range(0, LIM - 2 - model_v);
                    if (((model_v + a) % 2) != 0) a++;
                    cmd_op  = OP_SHF;
                    in_a    = W'(a);
                    model_v = (model_v + a) / 2;
                end else begin
                    a = $urandom_range(0, LIM - 1 - model_v);
                    cmd_op  = OP_ACC;
                    in_a    = W'(a);
                    model_v = model_v + a;
                end
                @(posedge clk);
                #1;
                chk("rnd_lsbs", {30'd0, lsb1, lsb0}, 32'(model_v % 4));
            end
        end
        cmd_valid = 1'b0;
        ref_resolve(model_v, 1'b0, 0, r, b, lat);
        do_resolve(1'b0, '0, W'(r), b, lat, "rnd_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
